// File: rtl/melody_sequencer.sv
// Plays a fixed 16-entry song ROM as a stream of note codes.
// Each entry is timed by beats (beat counter + beats left) and then a short gap.
module melody_sequencer #(
    parameter int BEAT_CYCLES = 12500000,
    parameter int GAP_CYCLES  = 1250000
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       start,
    input  logic       stop,
    input  logic       loop_en,
    output logic [2:0] en_count,
    output logic       playing,
    output logic       done,
    output logic [3:0] note_idx
);

    localparam int BW = (BEAT_CYCLES > 1) ? $clog2(BEAT_CYCLES) : 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [BW-1:0] BEAT_LAST = BW'(BEAT_CYCLES - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, NOTE, GAP} state_t;

    state_t          state, state_n;
    logic [BW-1:0]   beat_cnt, beat_n;
    logic [2:0]      beats_left, left_n;
    logic [GW-1:0]   gap_cnt, gap_n;
    logic [3:0]      idx_n, idx_inc;
    logic [2:0]      en_n;
    logic            done_n;

    function automatic logic [2:0] note_of(input logic [3:0] i);
        case (i)
            4'd0, 4'd3, 4'd4, 4'd7:   note_of = 3'd1;
            4'd1, 4'd5:               note_of = 3'd2;
            4'd2, 4'd6, 4'd8, 4'd11:  note_of = 3'd3;
            4'd9, 4'd12:              note_of = 3'd6;
            4'd10, 4'd13:             note_of = 3'd7;
            default:                  note_of = 3'd0;
        endcase
    endfunction

    // dur = 0 marks the end of the song
    function automatic logic [2:0] dur_of(input logic [3:0] i);
        case (i)
            4'd10, 4'd13:    dur_of = 3'd2;
            4'd14, 4'd15:    dur_of = 3'd0;
            default:         dur_of = 3'd1;
        endcase
    endfunction

    assign idx_inc = note_idx + 4'd1;

    always_comb begin
        state_n = state;
        idx_n   = note_idx;
        beat_n  = beat_cnt;
        left_n  = beats_left;
        gap_n   = gap_cnt;
        done_n  = 1'b0;
        if (stop) begin
            state_n = IDLE;
            idx_n   = 4'd0;
            beat_n  = '0;
            left_n  = 3'd0;
            gap_n   = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        idx_n  = 4'd0;
                        beat_n = '0;
                        gap_n  = '0;
                        if (dur_of(4'd0) != 3'd0) begin
                            state_n = NOTE;
                            left_n  = dur_of(4'd0);
                        end else begin
                            done_n = 1'b1;
                        end
                    end
                end
                NOTE: begin
                    if (beat_cnt == BEAT_LAST) begin
                        beat_n = '0;
                        if (beats_left == 3'd1) begin
                            state_n = GAP;
                            gap_n   = '0;
                        end else begin
                            left_n = beats_left - 3'd1;
                        end
                    end else begin
                        beat_n = beat_cnt + 1'b1;
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        gap_n  = '0;
                        beat_n = '0;
                        if (note_idx != 4'd15 && dur_of(idx_inc) != 3'd0) begin
                            state_n = NOTE;
                            idx_n   = idx_inc;
                            left_n  = dur_of(idx_inc);
                        end else if (loop_en && dur_of(4'd0) != 3'd0) begin
                            state_n = NOTE;
                            idx_n   = 4'd0;
                            left_n  = dur_of(4'd0);
                        end else begin
                            state_n = IDLE;
                            done_n  = 1'b1;
                        end
                    end else begin
                        gap_n = gap_cnt + 1'b1;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
        // outputs are registered from the next state so they line up with it
        en_n = (state_n == NOTE) ? note_of(idx_n) : 3'd0;
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            beat_cnt   <= '0;
            beats_left <= 3'd0;
            gap_cnt    <= '0;
            note_idx   <= 4'd0;
            en_count   <= 3'd0;
            playing    <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_n;
            beat_cnt   <= beat_n;
            beats_left <= left_n;
            gap_cnt    <= gap_n;
            note_idx   <= idx_n;
            en_count   <= en_n;
            playing    <= (state_n != IDLE);
            done       <= done_n;
        end
    end

endmodule

// File: tb/tb_melody_sequencer.sv
// Directed bench for melody_sequencer with BEAT_CYCLES=4, GAP_CYCLES=2.
// Cycle n is the interval after the n-th edge counted from the start edge (edge 0).
module tb_melody_sequencer;

    logic       CLOCK_50 = 1'b0;
    logic       reset, start, stop, loop_en;
    logic [2:0] en_count;
    logic       playing, done;
    logic [3:0] note_idx;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 CLOCK_50 = ~CLOCK_50;

    melody_sequencer #(.BEAT_CYCLES(4), .GAP_CYCLES(2)) dut (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .start    (start),
        .stop     (stop),
        .loop_en  (loop_en),
        .en_count (en_count),
        .playing  (playing),
        .done     (done),
        .note_idx (note_idx)
    );

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLOCK_50);
        #1;
        cyc++;
    endtask

    task automatic go;
        start = 1'b1;
        cyc   = 0;
        tick;
        start = 1'b0;
    endtask

    task automatic halt;
        stop = 1'b1;
        tick;
        stop = 1'b0;
    endtask

    task automatic intro(input string nm, input bit pulses);
        int e;
        go;
        for (int c = 1; c <= 10; c++) begin
            e = (c <= 4) ? 1 : (c <= 6) ? 0 : 2;
            chk($sformatf("%s_en_c%0d", nm, c), int'(en_count), e);
            chk($sformatf("%s_play_c%0d", nm, c), int'(playing), 1);
            chk($sformatf("%s_done_c%0d", nm, c), int'(done), 0);
            chk($sformatf("%s_idx_c%0d", nm, c), int'(note_idx), (c >= 7) ? 1 : 0);
            start = pulses && (c == 3 || c == 8);
            tick;
        end
        start = 1'b0;
        halt;
    endtask

    initial begin
        int dones, dcyc, entries, hold;
        logic [2:0] prev_en;

        reset = 1'b1; start = 1'b0; stop = 1'b0; loop_en = 1'b0;
        #3;
        chk("rst_en", int'(en_count), 0);
        chk("rst_play", int'(playing), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_idx", int'(note_idx), 0);
        #9 reset = 1'b0;
        tick;
        chk("idle_play", int'(playing), 0);

        intro("s1", 1'b0);
        intro("s5", 1'b1);

        // full song without looping
        dones = 0; dcyc = 0; entries = 0; hold = 0; prev_en = 3'd0;
        go;
        for (int c = 1; c <= 95; c++) begin
            if (prev_en != 3'd0 && en_count == 3'd0) entries++;
            prev_en = en_count;
            if (done) begin dones++; dcyc = c; end
            if (en_count == 3'd7 && note_idx == 4'd10) hold++;
            if (c == 92) chk("s2_play_c92", int'(playing), 1);
            if (c == 93) begin
                chk("s2_play_c93", int'(playing), 0);
                chk("s2_en_c93", int'(en_count), 0);
            end
            tick;
        end
        chk("s2_dones", dones, 1);
        chk("s2_done_cyc", dcyc, 93);
        chk("s2_entries", entries, 14);
        chk("s2_e10_hold", hold, 8);
        chk("s2_idx_held", int'(note_idx), 13);

        // start and stop together from idle: stop wins
        start = 1'b1; stop = 1'b1;
        tick;
        start = 1'b0; stop = 1'b0;
        chk("s4b_play", int'(playing), 0);
        chk("s4b_en", int'(en_count), 0);
        chk("s4b_idx", int'(note_idx), 0);
        chk("s4b_done", int'(done), 0);
        tick;
        chk("s4b_play2", int'(playing), 0);

        // looping, then loop_en cleared mid-song
        loop_en = 1'b1;
        dones = 0; dcyc = 0;
        go;
        for (int c = 1; c <= 188; c++) begin
            if (c == 100) loop_en = 1'b0;
            if (done) begin dones++; dcyc = c; end
            if (c == 93) begin
                chk("s3_en_c93", int'(en_count), 1);
                chk("s3_idx_c93", int'(note_idx), 0);
                chk("s3_play_c93", int'(playing), 1);
                chk("s3_nodone_c93", dones, 0);
            end
            if (c == 184) chk("s3_idx_c184", int'(note_idx), 13);
            if (c == 185) chk("s3_play_c185", int'(playing), 0);
            tick;
        end
        chk("s3_dones", dones, 1);
        chk("s3_done_cyc", dcyc, 185);

        // stop during NOTE
        go;
        repeat (19) tick;
        chk("s4a_idx_c20", int'(note_idx), 3);
        chk("s4a_en_c20", int'(en_count), 1);
        stop = 1'b1;
        tick;
        stop = 1'b0;
        chk("s4a_en", int'(en_count), 0);
        chk("s4a_play", int'(playing), 0);
        chk("s4a_idx", int'(note_idx), 0);
        chk("s4a_done", int'(done), 0);
        for (int k = 0; k < 3; k++) begin
            tick;
            chk($sformatf("s4a_done_after%0d", k), int'(done), 0);
            chk($sformatf("s4a_play_after%0d", k), int'(playing), 0);
        end

        // asynchronous reset in the gap of entry 1
        go;
        repeat (10) tick;
        chk("s6_play_c11", int'(playing), 1);
        chk("s6_en_c11", int'(en_count), 0);
        chk("s6_idx_c11", int'(note_idx), 1);
        #3 reset = 1'b1;
        #1;
        chk("s6_rst_play", int'(playing), 0);
        chk("s6_rst_idx", int'(note_idx), 0);
        chk("s6_rst_en", int'(en_count), 0);
        chk("s6_rst_done", int'(done), 0);
        @(posedge CLOCK_50);
        #2 reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick;
            chk($sformatf("s6_idle%0d_play", k), int'(playing), 0);
            chk($sformatf("s6_idle%0d_en", k), int'(en_count), 0);
        end
        go;
        chk("s6_restart_en", int'(en_count), 1);
        chk("s6_restart_play", int'(playing), 1);
        halt;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/melody_sequencer.md
MELODY_SEQUENCER -- requirements
Module: melody_sequencer

Interface
REQ-001 SHALL have parameter BEAT_CYCLES, default 12500000, clock cycles per beat (250 ms at 50 MHz).
REQ-002 SHALL have parameter GAP_CYCLES, default 1250000, silent cycles inserted after every entry; must be less than BEAT_CYCLES.
REQ-003 SHALL have port CLOCK_50  input  1  the single clock; all state is updated on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  request to play the song from entry 0.
REQ-006 SHALL have port stop  input  1  request to abort playback.
REQ-007 SHALL have port loop_en  input  1  when 1, the song restarts at entry 0 after the last entry instead of finishing.
REQ-008 SHALL have port en_count  output  3  note code for the downstream tone stage (0 = silent, 1..7 = note); registered.
REQ-009 SHALL have port playing  output  1  high while in state NOTE or GAP.
REQ-010 SHALL have port done  output  1  one-cycle pulse when the song finishes without looping.
REQ-011 SHALL have port note_idx  output  4  index of the current song entry.

Function
REQ-012 SHALL contain a fixed 16-entry song ROM; each entry is {note[2:0], dur[2:0]}, where dur is a length in beats and dur=0 is an end marker.
REQ-013 SHALL hold the following ROM contents, written as note/dur for entries 0-15: 1/1 2/1 3/1 1/1 1/1 2/1 3/1 1/1 3/1 6/1 7/2 3/1 6/1 7/2 0/0 0/0.
REQ-014 SHALL treat an entry with note=0 and dur≠0 as a rest: en_count=0 for dur beats, followed by the normal gap.
REQ-015 SHALL implement the states IDLE, NOTE and GAP.
REQ-016 IDLE behaviour: en_count=0, playing=0, note_idx held; on start=1 and stop=0 the block SHALL set note_idx=0 and go to NOTE if entry 0 has dur≠0, otherwise stay in IDLE and pulse done.
REQ-017 NOTE behaviour: en_count=ROM[note_idx].note; the block SHALL stay in NOTE for exactly dur×BEAT_CYCLES cycles, then go to GAP.
REQ-018 GAP behaviour: en_count=0 for exactly GAP_CYCLES cycles; the block SHALL then advance per REQ-019.
REQ-019 End of GAP: if note_idx=15 or ROM[note_idx+1].dur=0 the entry is last; if it is not last, the block SHALL set note_idx+1 and go to NOTE.
REQ-020 Last entry with loop_en=1: the block SHALL set note_idx=0 and go to NOTE in the next cycle.
REQ-021 Last entry with loop_en=0: the block SHALL go to IDLE with done=1 for exactly one cycle.
REQ-022 SHALL time each entry with a beat counter (0..BEAT_CYCLES-1) plus a beats-remaining counter (3 bit); wrap of the beat counter decrements beats-remaining. A single flat counter is not allowed.
REQ-023 SHALL size the gap counter to $clog2(GAP_CYCLES) bits.
REQ-024 Latency: start sampled at edge t SHALL give en_count=ROM[0].note and playing=1 from cycle t+1.
REQ-025 SHALL ignore start while playing=1.
REQ-026 stop=1 in any state SHALL force IDLE at the next edge with en_count=0, playing=0 and note_idx=0, and no done pulse.
REQ-027 stop and start asserted together: stop SHALL win.
REQ-028 loop_en SHALL be sampled only at the end of the last entry's GAP.
REQ-029 All outputs SHALL be registered, with no combinational path from inputs to outputs.

Reset
REQ-030 reset=1 SHALL immediately, without waiting for a clock edge, force state=IDLE, en_count=0, playing=0, done=0, note_idx=0 and clear all counters.
REQ-031 Reset asserted during NOTE or GAP SHALL abort playback; after release the block SHALL stay in IDLE until a new start.

Verification (BEAT_CYCLES=4, GAP_CYCLES=2)
REQ-032 Scenario 1: start pulse at edge 0 -> en_count=1 in cycles 1-4, 0 in cycles 5-6, 2 in cycles 7-10, and note_idx=1 from cycle 7.
REQ-033 Scenario 2: full song with loop_en=0 -> entry 10 (note 7) holds 8 cycles; final gap ends at cycle 92; done=1 only in cycle 93, where playing=0; in total 14 entries are played.
REQ-034 Scenario 3: loop_en=1 -> cycle 93 shows en_count=1 and note_idx=0 with no done pulse; clearing loop_en mid-song ends playback after entry 13.
REQ-035 Scenario 4: stop at cycle 20 (during NOTE), and separately start+stop in the same cycle from IDLE -> en_count=0 and playing=0 at the next edge, no done, and note_idx=0 in both cases.
REQ-036 Scenario 5: start pulses at cycles 3 and 8 while playing -> timing is identical to Scenario 1.
REQ-037 Scenario 6: reset asserted asynchronously mid-GAP, between clock edges -> outputs are zero before the next edge; after release the block stays idle until start.
